syndrome_calculator: RTL and testbench

- Syndrome stage of the DVB-T Reed-Solomon RS(204,188, t=8) decoder.
- Consumes one received byte per enabled clock and accumulates the 16 syndromes S_j = r(alpha^(j-1)), j = 1..16, over GF(2^8).
- After the last byte of each 204-byte codeword, it presents the syndromes to the downstream key-equation solver (Berlekamp-Massey / Euclid).

---
 rtl/syndrome_calculator.sv | 119 +++++++++++
 tb/tb_syndrome_calculator.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/syndrome_calculator.sv
// ---------------------------------------------------------------------------
// syndrome_calculator
//   Syndrome stage of the DVB-T RS(204,188, t=8) decoder. Each enabled clock
//   consumes one received byte (highest-degree coefficient r_203 first) and
//   Horner-accumulates the 16 syndromes S_j = r(alpha^(j-1)) over GF(2^8).
//   On the edge that consumes r_0 the finished syndromes are registered onto
//   S_1..S_16, and the accumulators restart so the next codeword may follow
//   on the very next clock.
//
// Ports
//   Clk        rising-edge clock
//   Reset      synchronous, active-high; clears accumulators, counter, outputs
//   Msg_Rsv    received symbol, consumed only when CS=1
//   CS         symbol enable
//   S_1..S_16  registered syndromes, updated only on the last-symbol edge
//
// Handshake: CS is a one-way enable (valid without ready). The block has no
//   backpressure; a byte is taken on every rising edge with CS=1 and
//   Reset=0, and CS=0 cycles may appear anywhere without affecting results.
// ---------------------------------------------------------------------------
module syndrome_calculator #(
   parameter int         N         = 204,
   parameter int         NSYN      = 16,
   parameter logic [8:0] PRIM_POLY = 9'h11D
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] Msg_Rsv,
   input  logic       CS,
   output logic [7:0] S_1,
   output logic [7:0] S_2,
   output logic [7:0] S_3,
   output logic [7:0] S_4,
   output logic [7:0] S_5,
   output logic [7:0] S_6,
   output logic [7:0] S_7,
   output logic [7:0] S_8,
   output logic [7:0] S_9,
   output logic [7:0] S_10,
   output logic [7:0] S_11,
   output logic [7:0] S_12,
   output logic [7:0] S_13,
   output logic [7:0] S_14,
   output logic [7:0] S_15,
   output logic [7:0] S_16
);

   localparam logic [7:0] LAST_SYM = 8'(N - 1);

   logic [7:0] acc     [NSYN];
   logic [7:0] syn     [NSYN];
   logic [7:0] acc_nxt [NSYN];
   logic [7:0] sym_cnt;

   // Multiply by alpha (x) with reduction by the field polynomial.
   function automatic logic [7:0] mul_alpha(input logic [7:0] a);
      mul_alpha = {a[6:0], 1'b0} ^ (a[7] ? PRIM_POLY[7:0] : 8'h00);
   endfunction

   // Multiply by alpha^k for a constant k: the loop unrolls into a fixed
   // XOR network, so no general multiplier is built.
   function automatic logic [7:0] mul_alpha_pow(input logic [7:0] a, input int k);
      logic [7:0] r;
      r = a;
      for (int i = 0; i < k; i++) begin
         r = mul_alpha(r);
      end
      return r;
   endfunction

   // Horner step for every syndrome; index j holds S_(j+1) = r(alpha^j).
   always_comb begin
      for (int j = 0; j < NSYN; j++) begin
         acc_nxt[j] = mul_alpha_pow(acc[j], j) ^ Msg_Rsv;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int j = 0; j < NSYN; j++) begin
            acc[j] <= 8'h00;
            syn[j] <= 8'h00;
         end
         sym_cnt <= 8'h00;
      end else if (CS) begin
         if (sym_cnt == LAST_SYM) begin
            // r_0 consumed: publish the finished syndromes and restart.
            for (int j = 0; j < NSYN; j++) begin
               syn[j] <= acc_nxt[j];
               acc[j] <= 8'h00;
            end
            sym_cnt <= 8'h00;
         end else begin
            for (int j = 0; j < NSYN; j++) begin
               acc[j] <= acc_nxt[j];
            end
            sym_cnt <= sym_cnt + 8'd1;
         end
      end
   end

   assign S_1  = syn[0];
   assign S_2  = syn[1];
   assign S_3  = syn[2];
   assign S_4  = syn[3];
   assign S_5  = syn[4];
   assign S_6  = syn[5];
   assign S_7  = syn[6];
   assign S_8  = syn[7];
   assign S_9  = syn[8];
   assign S_10 = syn[9];
   assign S_11 = syn[10];
   assign S_12 = syn[11];
   assign S_13 = syn[12];
   assign S_14 = syn[13];
   assign S_15 = syn[14];
   assign S_16 = syn[15];

endmodule

// File: tb/tb_syndrome_calculator.sv
// ---------------------------------------------------------------------------
// tb_syndrome_calculator
//   Drives codewords into syndrome_calculator and checks S_1..S_16 every
//   cycle against a reference that evaluates r(alpha^(j-1)) directly as a
//   polynomial sum over the buffered codeword, plus literal expectations for
//   the zero, valid, degree-1 and degree-0 codewords.
// ---------------------------------------------------------------------------
module tb_syndrome_calculator;

   localparam int N = 204;

   // ---------------- clock / reset ----------------
   logic       Clk = 1'b0;
   logic       Reset;
   logic       CS;
   logic [7:0] Msg_Rsv;
   logic [7:0] S_1, S_2, S_3, S_4, S_5, S_6, S_7, S_8;
   logic [7:0] S_9, S_10, S_11, S_12, S_13, S_14, S_15, S_16;

   always #5 Clk = ~Clk;

   syndrome_calculator #(.N(N), .NSYN(16), .PRIM_POLY(9'h11D)) dut (
      .Clk(Clk), .Reset(Reset), .Msg_Rsv(Msg_Rsv), .CS(CS),
      .S_1(S_1), .S_2(S_2), .S_3(S_3), .S_4(S_4),
      .S_5(S_5), .S_6(S_6), .S_7(S_7), .S_8(S_8),
      .S_9(S_9), .S_10(S_10), .S_11(S_11), .S_12(S_12),
      .S_13(S_13), .S_14(S_14), .S_15(S_15), .S_16(S_16)
   );

   logic [127:0] dut_vec;
   assign dut_vec = {S_1, S_2, S_3, S_4, S_5, S_6, S_7, S_8,
                     S_9, S_10, S_11, S_12, S_13, S_14, S_15, S_16};

   int tests_run = 0;
   int tests_failed = 0;

   // ---------------- GF(2^8) arithmetic ----------------
   logic [7:0] alog [255];
   logic [7:0] g_poly [17];
   logic [7:0] cw_buf [N];

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] x;
      r = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
      end
      return r;
   endfunction

   // ---------------- reference model ----------------
   logic [7:0]   exp_q [$];      // symbols of the codeword in progress
   logic [127:0] exp_cur = '0;
   bit           started = 1'b0;

   function automatic logic [127:0] eval_syndromes();
      logic [127:0] v;
      logic [7:0]   s;
      v = '0;
      for (int j = 0; j < 16; j++) begin
         s = 8'h00;
         for (int k = 0; k < N; k++) begin
            s = s ^ gf_mul(exp_q[k], alog[(j * (N - 1 - k)) % 255]);
         end
         v[127 - 8*j -: 8] = s;
      end
      return v;
   endfunction

   always @(posedge Clk) begin
      started <= 1'b1;
      if (Reset) begin
         exp_q.delete();
         exp_cur <= '0;
      end else if (CS) begin
         exp_q.push_back(Msg_Rsv);
         if (exp_q.size() == N) begin
            exp_cur <= eval_syndromes();
            exp_q.delete();
         end
      end
   end

   // ---------------- scoreboard ----------------
   always @(negedge Clk) begin
      if (started) begin
         tests_run++;
         if (dut_vec !== exp_cur) begin
            tests_failed++;
            $display("FAIL cycle_compare t=%0t got=%032h exp=%032h", $time, dut_vec, exp_cur);
         end
      end
   end

   task automatic check_lit(input string name, input logic [127:0] exp);
      tests_run++;
      if (dut_vec !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%032h exp=%032h", name, dut_vec, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk); #1;
         Reset   = 1'b0;
         CS      = 1'b0;
         Msg_Rsv = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk); #1;
         Reset   = 1'b1;
         CS      = 1'($urandom_range(0, 1));
         Msg_Rsv = 8'($urandom_range(0, 255));
      end
      @(posedge Clk); #1;
      Reset = 1'b0;
      CS    = 1'b0;
   endtask

   // Sends cw_buf[first..last]; optional random idle gaps between symbols.
   task automatic send_range(input int first, input int last, input bit gaps);
      for (int k = first; k <= last; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         @(posedge Clk); #1;
         Reset   = 1'b0;
         CS      = 1'b1;
         Msg_Rsv = cw_buf[k];
      end
   endtask

   // Sends a whole codeword and lets the last symbol be consumed.
   task automatic send_cw(input bit gaps);
      send_range(0, N - 1, gaps);
      idle(1);
   endtask

   task automatic fill_const(input logic [7:0] v);
      for (int k = 0; k < N; k++) cw_buf[k] = v;
   endtask

   // Systematic RS(204,188) encode of cw_buf[0..187] into cw_buf[188..203].
   task automatic gen_valid();
      logic [7:0] p [16];
      logic [7:0] fb;
      for (int i = 0; i < 16; i++) p[i] = 8'h00;
      for (int m = 0; m < 188; m++) begin
         cw_buf[m] = 8'($urandom_range(0, 255));
         fb = cw_buf[m] ^ p[15];
         for (int i = 15; i > 0; i--) p[i] = p[i-1] ^ gf_mul(fb, g_poly[i]);
         p[0] = gf_mul(fb, g_poly[0]);
      end
      for (int i = 0; i < 16; i++) cw_buf[188 + i] = p[15 - i];
   endtask

   localparam logic [127:0] DEG1_SYN = 128'h01020408_10204080_1D3A74E8_CD871326;

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] a;
      a = 8'h01;
      for (int i = 0; i < 255; i++) begin
         alog[i] = a;
         a = gf_mul(a, 8'h02);
      end
      for (int k = 0; k < 17; k++) g_poly[k] = 8'h00;
      g_poly[0] = 8'h01;
      for (int r = 0; r < 16; r++) begin
         for (int k = 16; k > 0; k--) g_poly[k] = g_poly[k-1] ^ gf_mul(g_poly[k], alog[r]);
         g_poly[0] = gf_mul(g_poly[0], alog[r]);
      end

      Reset = 1'b1; CS = 1'b0; Msg_Rsv = 8'h00;
      do_reset(3);
      check_lit("reset_zero", '0);

      // all-zero codeword
      fill_const(8'h00);
      send_cw(1'b0);
      check_lit("zero_cw", '0);

      // valid codewords, contiguous and gapped
      gen_valid();
      send_cw(1'b0);
      check_lit("valid_cw", '0);
      gen_valid();
      send_cw(1'b1);
      check_lit("valid_cw_gaps", '0);

      // single error at degree 1
      fill_const(8'h00);
      cw_buf[202] = 8'h01;
      send_cw(1'b0);
      check_lit("deg1_err", DEG1_SYN);

      // error at degree 0, then same with gaps (outputs held meanwhile)
      fill_const(8'h00);
      cw_buf[203] = 8'h5A;
      send_cw(1'b0);
      check_lit("deg0_err", {16{8'h5A}});
      send_cw(1'b1);
      check_lit("deg0_err_gaps", {16{8'h5A}});

      // back-to-back: errored then valid, no gap between them
      fill_const(8'h00);
      cw_buf[202] = 8'h01;
      send_range(0, N - 1, 1'b0);
      gen_valid();
      send_range(0, N - 2, 1'b0);
      check_lit("b2b_first_held", DEG1_SYN);
      send_range(N - 1, N - 1, 1'b0);
      idle(1);
      check_lit("b2b_second", '0);

      // reset in the middle of a codeword
      gen_valid();
      cw_buf[50] = cw_buf[50] ^ 8'h33;
      send_range(0, 99, 1'b0);
      @(posedge Clk); #1;
      Reset = 1'b1; CS = 1'b1; Msg_Rsv = 8'hA5;
      @(posedge Clk); #1;
      check_lit("mid_reset_zero", '0);
      Reset = 1'b0; CS = 1'b0;
      fill_const(8'h00);
      cw_buf[202] = 8'h01;
      send_cw(1'b1);
      check_lit("after_mid_reset", DEG1_SYN);

      // random codewords with random errors and gaps
      for (int it = 0; it < 4; it++) begin
         gen_valid();
         for (int e = 0; e < $urandom_range(0, 8); e++) begin
            cw_buf[$urandom_range(0, N - 1)] ^= 8'($urandom_range(1, 255));
         end
         send_cw(1'($urandom_range(0, 1)));
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
